// File: rtl/rf_port_scrubber_pkg.sv
// -----------------------------------------------------------------------------
// rf_port_scrubber_pkg
// Shared types and constants for the register-file read-port scrubber.
//   rps_mode_e : decoding of the 2-bit scrub mode field (mhrdctrl0[5:4]).
//   rf_add_t   : register-file address type.
//   rps_cnt_w  : width needed to hold the values 0..n (never less than 1).
// -----------------------------------------------------------------------------
package rf_port_scrubber_pkg;

   localparam int RF_AW = 5;

   // Address of one architectural register in the register file.
   typedef logic [RF_AW-1:0] rf_add_t;

   // Both 00 and 01 switch the scrubber off; bit 1 enables scrubbing and
   // bit 0 additionally arms the starvation monitor.
   typedef enum logic [1:0] {
      RPS_MODE_OFF     = 2'b00,
      RPS_MODE_OFF_ALT = 2'b01,
      RPS_MODE_SCRUB   = 2'b10,
      RPS_MODE_RESTART = 2'b11
   } rps_mode_e;

   function automatic int rps_cnt_w(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/rf_port_scrubber_wrap_add.sv
// -----------------------------------------------------------------------------
// rps_wrap_add
// Combinational modular adder: sum = wrap(base + offset), where the result is
// folded back into the window [FIRST_ADD, LAST_ADD].
// Ports:
//   base   in  AW  base address, assumed inside the window
//   offset in  OW  unsigned offset added to base
//   sum    out AW  wrapped address
// The addition and modulo are done on AW+OW bits so nothing is lost before
// the fold.
// -----------------------------------------------------------------------------
module rps_wrap_add #(
   parameter int AW        = 5,
   parameter int OW        = 2,
   parameter int FIRST_ADD = 1,
   parameter int LAST_ADD  = 31
) (
   input  logic [AW-1:0] base,
   input  logic [OW-1:0] offset,
   output logic [AW-1:0] sum
);

   localparam int            IW      = AW + OW;
   localparam logic [IW-1:0] FIRST_W = IW'(FIRST_ADD);
   localparam logic [IW-1:0] SPAN_W  = IW'(LAST_ADD - FIRST_ADD + 1);

   logic [IW-1:0] raw;
   logic [IW-1:0] rel;

   always_comb begin
      raw = IW'(base) + IW'(offset);
      rel = raw - FIRST_W;
      sum = AW'(FIRST_W + (rel % SPAN_W));
   end

endmodule

// File: rtl/rf_port_scrubber.sv
// -----------------------------------------------------------------------------
// rf_port_scrubber
// Steers idle register-file read ports onto a rotating scrub address so the
// OP stage re-reads and checks every register over time. Free ports in one
// cycle get consecutive addresses; the base advances by the number of ports
// used. An optional starvation monitor requests a pipeline restart when too
// few cycles in a 2^WIN_W window made scrub progress.
//
// Configuration macro: RF_PORT_SCRUB_RESTART_EN
//   defined     : starvation monitor present (mode 11)
//   not defined : monitor removed, s_restart_o tied 0, mode 11 acts as 10
//
// Ports:
//   s_clk_i       in  1      clock
//   s_reset_i     in  1      synchronous active-high reset
//   s_mode_i      in  2      00/01 off, 10 scrub, 11 scrub+restart
//   s_stall_i     in  1      ID stalled, OP holds a valid instruction
//   s_flush_i     in  1      ID flush (including a fed-back restart)
//   s_nop_i       in  1      aligner output not valid
//   s_id_free_i   in  RP     decoded instruction does not need port p
//   s_op_free_i   in  RP     instruction in OP does not need port p
//   s_scrub_o     out RP     port p loads its scrub address this cycle
//   s_port_add_o  out RP*AW  scrub address of port p (slice p*AW +: AW)
//   s_add_o       out AW     current base scrub address
//   s_restart_o   out 1      registered one-cycle restart request
// -----------------------------------------------------------------------------
module rf_port_scrubber
   import rf_port_scrubber_pkg::*;
#(
   parameter int RP        = 2,
   parameter int AW        = 5,
   parameter int FIRST_ADD = 1,
   parameter int LAST_ADD  = 31,
   parameter int WIN_W     = 4,
   parameter int MIN_UPD   = 4
) (
   input  logic             s_clk_i,
   input  logic             s_reset_i,
   input  logic [1:0]       s_mode_i,
   input  logic             s_stall_i,
   input  logic             s_flush_i,
   input  logic             s_nop_i,
   input  logic [RP-1:0]    s_id_free_i,
   input  logic [RP-1:0]    s_op_free_i,
   output logic [RP-1:0]    s_scrub_o,
   output logic [RP*AW-1:0] s_port_add_o,
   output logic [AW-1:0]    s_add_o,
   output logic             s_restart_o
);

   // Offset width: must hold RP itself (the base advance when all ports are free).
   localparam int OW = $clog2(RP) + 1;

   rps_mode_e        mode;
   logic             scrub_en;
   logic [RP-1:0]    free;
   logic [OW-1:0]    port_off [RP];
   logic [OW-1:0]    free_cnt;
   logic [OW-1:0]    next_off;
   logic [AW-1:0]    port_wrap [RP];
   logic [AW-1:0]    next_add;
   logic [AW-1:0]    add_q;

   assign mode     = rps_mode_e'(s_mode_i);
   assign scrub_en = (mode == RPS_MODE_SCRUB) || (mode == RPS_MODE_RESTART);

   // Free set in priority order, then the prefix count of free ports below
   // each port, which is that port's offset from the base address.
   // NOTE: every always_comb output gets a default first so no path leaves
   // it unassigned; otherwise synthesis infers a latch.
   always_comb begin
      free     = s_id_free_i;
      free_cnt = '0;
      if (s_flush_i)      free = '1;
      else if (s_stall_i) free = s_op_free_i;
      else if (s_nop_i)   free = '1;
      for (int p = 0; p < RP; p++) begin
         port_off[p] = free_cnt;
         if (free[p]) free_cnt = free_cnt + OW'(1);
      end
   end

   // A flush discards the ID instruction, so nothing is scrubbed, but the
   // base still moves on by one to keep the rotation going.
   assign next_off = s_flush_i ? OW'(1) : free_cnt;

   for (genvar p = 0; p < RP; p++) begin : g_port
      rps_wrap_add #(
         .AW        (AW),
         .OW        (OW),
         .FIRST_ADD (FIRST_ADD),
         .LAST_ADD  (LAST_ADD)
      ) u_port_add (
         .base   (add_q),
         .offset (port_off[p]),
         .sum    (port_wrap[p])
      );
      assign s_port_add_o[p*AW +: AW] = free[p] ? port_wrap[p] : add_q;
   end

   rps_wrap_add #(
      .AW        (AW),
      .OW        (OW),
      .FIRST_ADD (FIRST_ADD),
      .LAST_ADD  (LAST_ADD)
   ) u_next_add (
      .base   (add_q),
      .offset (next_off),
      .sum    (next_add)
   );

   assign s_scrub_o = (scrub_en && !s_flush_i) ? free : '0;
   assign s_add_o   = add_q;

   // NOTE: state registers use non-blocking assignments so every flop
   // samples the values from before the edge, independent of block order.
   always_ff @(posedge s_clk_i) begin
      if (s_reset_i)     add_q <= AW'(FIRST_ADD);
      else if (scrub_en) add_q <= next_add;
   end

`ifdef RF_PORT_SCRUB_RESTART_EN
   localparam int UW = rps_cnt_w(MIN_UPD);

   logic             mon_en;
   logic [WIN_W-1:0] win_cnt_q;
   logic [UW-1:0]    upd_cnt_q;
   logic [UW-1:0]    upd_cnt_d;
   logic             restart_q;

   assign mon_en = (mode == RPS_MODE_RESTART);

   // Update count including the current cycle, saturating at MIN_UPD.
   always_comb begin
      upd_cnt_d = upd_cnt_q;
      if ((s_flush_i || (free_cnt != '0)) && (upd_cnt_q < UW'(MIN_UPD)))
         upd_cnt_d = upd_cnt_q + UW'(1);
   end

   // Counters only run in mode 11; the restart flop defaults low so a
   // request lasts exactly one cycle after the window end.
   always_ff @(posedge s_clk_i) begin
      if (s_reset_i || !mon_en) begin
         win_cnt_q <= '0;
         upd_cnt_q <= '0;
         restart_q <= 1'b0;
      end else if (&win_cnt_q) begin
         win_cnt_q <= '0;
         upd_cnt_q <= '0;
         restart_q <= (upd_cnt_d < UW'(MIN_UPD));
      end else begin
         win_cnt_q <= win_cnt_q + WIN_W'(1);
         upd_cnt_q <= upd_cnt_d;
         restart_q <= 1'b0;
      end
   end

   assign s_restart_o = restart_q;
`else
   assign s_restart_o = 1'b0;
`endif

endmodule

// File: tb/tb_rf_port_scrubber.sv
// -----------------------------------------------------------------------------
// tb_rf_port_scrubber
// Directed bench for rf_port_scrubber (default parameters) plus a second
// instance with a 3-entry window (FIRST_ADD=4, LAST_ADD=6). A reference model
// tracks the base address and starvation window with plain integer
// arithmetic and is compared against the main DUT every cycle; literal
// expectations pin the scenarios of interest.
// -----------------------------------------------------------------------------
module tb_rf_port_scrubber;

   localparam int RP = 2;
   localparam int AW = 5;
   localparam int FIRST = 1;
   localparam int LAST = 31;
   localparam int WIN = 16;
   localparam int MIN_UPD = 4;

`ifdef RF_PORT_SCRUB_RESTART_EN
   localparam bit RESTART_EN = 1'b1;
`else
   localparam bit RESTART_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             s_reset = 1'b1;
   logic [1:0]       s_mode = 2'b00;
   logic             s_stall = 1'b0;
   logic             s_flush = 1'b0;
   logic             s_nop = 1'b0;
   logic [RP-1:0]    s_id_free = '0;
   logic [RP-1:0]    s_op_free = '0;
   logic [RP-1:0]    s_scrub;
   logic [RP*AW-1:0] s_port_add;
   logic [AW-1:0]    s_add;
   logic             s_restart;

   logic [1:0]       b_mode = 2'b00;
   logic [RP-1:0]    b_id_free = '0;
   logic [RP-1:0]    b_scrub;
   logic [RP*AW-1:0] b_port_add;
   logic [AW-1:0]    b_add;
   logic             b_restart;

   int n_tests = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   rf_port_scrubber #(
      .RP(RP), .AW(AW), .FIRST_ADD(FIRST), .LAST_ADD(LAST), .WIN_W(4), .MIN_UPD(MIN_UPD)
   ) u_dut (
      .s_clk_i(clk), .s_reset_i(s_reset), .s_mode_i(s_mode), .s_stall_i(s_stall),
      .s_flush_i(s_flush), .s_nop_i(s_nop), .s_id_free_i(s_id_free),
      .s_op_free_i(s_op_free), .s_scrub_o(s_scrub), .s_port_add_o(s_port_add),
      .s_add_o(s_add), .s_restart_o(s_restart)
   );

   rf_port_scrubber #(
      .RP(RP), .AW(AW), .FIRST_ADD(4), .LAST_ADD(6), .WIN_W(4), .MIN_UPD(MIN_UPD)
   ) u_small (
      .s_clk_i(clk), .s_reset_i(s_reset), .s_mode_i(b_mode), .s_stall_i(1'b0),
      .s_flush_i(1'b0), .s_nop_i(1'b0), .s_id_free_i(b_id_free),
      .s_op_free_i(2'b00), .s_scrub_o(b_scrub), .s_port_add_o(b_port_add),
      .s_add_o(b_add), .s_restart_o(b_restart)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   function automatic int wrapf(input int x);
      return FIRST + ((x - FIRST) % (LAST - FIRST + 1));
   endfunction

   function automatic logic [RP-1:0] free_set();
      if (s_flush) return '1;
      if (s_stall) return s_op_free;
      if (s_nop)   return '1;
      return s_id_free;
   endfunction

   function automatic int popc(input logic [RP-1:0] v);
      int c = 0;
      for (int i = 0; i < RP; i++) c += int'(v[i]);
      return c;
   endfunction

   bit m_valid = 1'b0;
   int m_add = FIRST;
   int m_cycles = 0;
   int m_updates = 0;
   bit m_restart = 1'b0;

   always @(posedge clk) begin
      logic [RP-1:0] f;
      f = free_set();
      if (s_reset) begin
         m_valid = 1'b1;
         m_add = FIRST;
         m_cycles = 0;
         m_updates = 0;
         m_restart = 1'b0;
      end else if (m_valid) begin
         m_restart = 1'b0;
         if (s_mode[1]) m_add = wrapf(m_add + (s_flush ? 1 : popc(f)));
         if (RESTART_EN && s_mode == 2'b11) begin
            m_cycles++;
            if (s_flush || popc(f) > 0) m_updates++;
            if (m_cycles == WIN) begin
               m_restart = (m_updates < MIN_UPD);
               m_cycles = 0;
               m_updates = 0;
            end
         end else begin
            m_cycles = 0;
            m_updates = 0;
         end
      end
   end

   // Per-cycle comparison, away from the active edge.
   always @(negedge clk) begin
      if (m_valid) begin
         logic [RP-1:0] f;
         logic [RP-1:0] exp_scrub;
         int k;
         f = free_set();
         exp_scrub = (s_mode[1] && !s_flush) ? f : '0;
         check("model scrub", 32'(s_scrub), 32'(exp_scrub));
         check("model add", 32'(s_add), 32'(m_add));
         check("model restart", 32'(s_restart), 32'(m_restart));
         k = 0;
         for (int p = 0; p < RP; p++) begin
            if (f[p]) begin
               if (exp_scrub[p])
                  check($sformatf("model port_add[%0d]", p),
                        32'(s_port_add[p*AW +: AW]), 32'(wrapf(m_add + k)));
               k++;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- directed stimulus ----------------
   initial begin
      tick(); tick();
      s_reset = 1'b0;
      @(negedge clk);
      check("reset add", 32'(s_add), 1);
      check("reset scrub", 32'(s_scrub), 0);
      check("reset restart", 32'(s_restart), 0);

      // Both ports free from add=1, then port 1 only.
      tick(); s_mode = 2'b10; s_id_free = 2'b11;
      @(negedge clk);
      check("p0 first", 32'(s_port_add[0 +: AW]), 1);
      check("p1 first", 32'(s_port_add[AW +: AW]), 2);
      check("scrub 11", 32'(s_scrub), 2'b11);
      tick(); s_id_free = 2'b10;
      @(negedge clk);
      check("add after two", 32'(s_add), 3);
      check("p1 alone", 32'(s_port_add[AW +: AW]), 3);
      check("scrub 10", 32'(s_scrub), 2'b10);
      tick(); s_id_free = 2'b00; s_mode = 2'b00;
      @(negedge clk);
      check("add after one", 32'(s_add), 4);

      // Walk the base to 31, then a nop frees both ports across the wrap.
      tick(); s_mode = 2'b10; s_id_free = 2'b11;
      repeat (13) tick();
      s_id_free = 2'b01;
      tick(); s_id_free = 2'b00; s_nop = 1'b1;
      @(negedge clk);
      check("add at top", 32'(s_add), 31);
      check("p0 wrap", 32'(s_port_add[0 +: AW]), 31);
      check("p1 wrap", 32'(s_port_add[AW +: AW]), 1);
      tick(); s_nop = 1'b0; s_mode = 2'b00;
      @(negedge clk);
      check("add wrapped", 32'(s_add), 2);

      // Flush with add=9.
      tick(); s_mode = 2'b10; s_id_free = 2'b11;
      repeat (3) tick();
      s_id_free = 2'b01;
      tick(); s_id_free = 2'b00; s_flush = 1'b1;
      @(negedge clk);
      check("add before flush", 32'(s_add), 9);
      check("flush scrub", 32'(s_scrub), 0);
      tick(); s_flush = 1'b0;
      @(negedge clk);
      check("add after flush", 32'(s_add), 10);

      // Starvation: stall with no OP-free ports for a full window.
      tick(); s_mode = 2'b11; s_stall = 1'b1;
      repeat (16) tick();
      @(negedge clk);
      check("starved restart", 32'(s_restart), 32'(RESTART_EN));
      tick();
      @(negedge clk);
      check("restart one cycle", 32'(s_restart), 0);
      s_mode = 2'b10;
      repeat (17) tick();
      check("mode 10 no restart", 32'(s_restart), 0);

      // Exactly MIN_UPD updates, then one short, then flush at window end.
      s_stall = 1'b0; s_mode = 2'b00;
      tick(); s_mode = 2'b11; s_id_free = 2'b01;
      repeat (4) tick();
      s_id_free = 2'b00;
      repeat (12) tick();
      check("4 updates no restart", 32'(s_restart), 0);
      s_id_free = 2'b01;
      repeat (3) tick();
      s_id_free = 2'b00;
      repeat (13) tick();
      check("3 updates restart", 32'(s_restart), 32'(RESTART_EN));
      s_id_free = 2'b01;
      repeat (3) tick();
      s_id_free = 2'b00;
      repeat (12) tick();
      s_flush = 1'b1;
      tick(); s_flush = 1'b0;
      check("flush at window end", 32'(s_restart), 0);

      // Reset at win_cnt=12: no pulse at the old boundary, new window after.
      s_mode = 2'b00;
      tick(); s_mode = 2'b11;
      repeat (12) tick();
      s_reset = 1'b1;
      tick(); s_reset = 1'b0;
      @(negedge clk);
      check("mid reset add", 32'(s_add), 1);
      repeat (3) tick();
      check("no pulse old boundary", 32'(s_restart), 0);
      repeat (13) tick();
      check("pulse new boundary", 32'(s_restart), 32'(RESTART_EN));
      s_mode = 2'b00;

      // Narrow window FIRST_ADD=4, LAST_ADD=6.
      tick(); b_mode = 2'b10; b_id_free = 2'b11;
      @(negedge clk);
      check("small reset add", 32'(b_add), 4);
      check("small p1 first", 32'(b_port_add[AW +: AW]), 5);
      tick();
      @(negedge clk);
      check("small p0 at 6", 32'(b_port_add[0 +: AW]), 6);
      check("small p1 wrap", 32'(b_port_add[AW +: AW]), 4);
      tick(); b_mode = 2'b00;
      @(negedge clk);
      check("small next add", 32'(b_add), 5);
      check("small restart", 32'(b_restart), 0);

      tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
